// File: rtl/dac_pkg.sv
// Shared constants and FSM encoding for the audio DAC serial write path.
package dac_pkg;
  localparam int         FRAME_BITS = 16;
  localparam int         DATA_BITS  = 12;
  localparam logic [3:0] CMD_WRITE  = 4'h3;
  localparam int         GAP_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;
endpackage

// File: rtl/dac_shift_out.sv
// MSB-first frame serializer: SCLK runs at clk/2, SDI changes only on the low phase.
module dac_shift_out #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] word,
  input  logic         abort,
  output logic         done,
  output logic         sclk,
  output logic         sdi,
  output logic         cs_n
);
  localparam int CW = $clog2(W);

  // MSB goes straight to the SDI register on load, so only the tail is kept.
  logic [W-2:0]  sr;
  logic [CW-1:0] cnt;
  logic          phase;
  logic          active;

  assign done = active && phase && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      active <= 1'b0;
      phase  <= 1'b0;
      cnt    <= '0;
      sr     <= '0;
      sclk   <= 1'b0;
      sdi    <= 1'b0;
      cs_n   <= 1'b1;
    end else if (load) begin
      active <= 1'b1;
      phase  <= 1'b0;
      cnt    <= CW'(W-1);
      sr     <= word[W-2:0];
      sclk   <= 1'b0;
      sdi    <= word[W-1];
      cs_n   <= 1'b0;
    end else if (active) begin
      if (!phase) begin
        phase <= 1'b1;
        sclk  <= 1'b1;
      end else if (cnt == '0) begin
        active <= 1'b0;
        phase  <= 1'b0;
        sclk   <= 1'b0;
        sdi    <= 1'b0;
        cs_n   <= 1'b1;
      end else begin
        phase <= 1'b0;
        cnt   <= cnt - CW'(1);
        sr    <= {sr[W-3:0], 1'b0};
        sdi   <= sr[W-2];
        sclk  <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/dac_write_ctrl.sv
// DAC write sequencer: config/sample arbiter, frame FSM with abort on readiness loss, GAP timer.
module dac_write_ctrl #(
  parameter int FRAME_BITS = dac_pkg::FRAME_BITS,
  parameter int DATA_BITS  = dac_pkg::DATA_BITS,
  parameter logic [FRAME_BITS-DATA_BITS-1:0] CMD_WRITE = dac_pkg::CMD_WRITE,
  parameter int GAP_CYCLES = dac_pkg::GAP_CYCLES
) (
  input  logic                  clk12Mhz,
  input  logic                  RESET,
  input  logic                  dac_ready,
  input  logic                  cfg_req,
  input  logic [FRAME_BITS-1:0] cfg_word,
  output logic                  cfg_ack,
  input  logic                  smp_valid,
  input  logic [DATA_BITS-1:0]  smp_data,
  output logic                  smp_ready,
  output logic                  dac_sclk,
  output logic                  dac_sdi,
  output logic                  dac_cs_n,
  output logic                  busy,
  output logic                  frame_abort
);
  import dac_pkg::*;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t                state;
  logic [GW-1:0]         gap_cnt;
  logic                  load;
  logic                  abort;
  logic                  done;
  logic [FRAME_BITS-1:0] word;

  // Handshakes are masked during reset so nothing is acknowledged and then dropped.
  assign cfg_ack   = !RESET && (state == ST_IDLE) && dac_ready && cfg_req;
  assign smp_ready = !RESET && (state == ST_IDLE) && dac_ready && !cfg_req;
  assign load      = cfg_ack || (smp_ready && smp_valid);
  assign abort     = (state == ST_SHIFT) && !dac_ready;
  assign word      = cfg_ack ? cfg_word : {CMD_WRITE, smp_data};

  dac_shift_out #(.W(FRAME_BITS)) u_shift (
    .clk   (clk12Mhz),
    .rst   (RESET),
    .load  (load),
    .word  (word),
    .abort (abort),
    .done  (done),
    .sclk  (dac_sclk),
    .sdi   (dac_sdi),
    .cs_n  (dac_cs_n)
  );

  always_ff @(posedge clk12Mhz) begin
    if (RESET) begin
      state       <= ST_IDLE;
      gap_cnt     <= '0;
      busy        <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_abort <= 1'b0;
      case (state)
        ST_IDLE: if (load) begin
          state <= ST_SHIFT;
          busy  <= 1'b1;
        end
        // Abort wins over a coincident done; the word is dropped either way.
        ST_SHIFT: if (abort || done) begin
          state       <= ST_GAP;
          gap_cnt     <= GW'(GAP_CYCLES - 1);
          frame_abort <= abort;
        end
        ST_GAP: if (gap_cnt == '0) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end else begin
          gap_cnt <= gap_cnt - GW'(1);
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dac_write_ctrl.sv
// Directed bench: stimulus pushes expected frames; a pin monitor decodes and scores them.
module tb_dac_write_ctrl;
  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        dac_ready = 1'b0;
  logic        cfg_req = 1'b0;
  logic [15:0] cfg_word = '0;
  logic        cfg_ack;
  logic        smp_valid = 1'b0;
  logic [11:0] smp_data = '0;
  logic        smp_ready;
  logic        dac_sclk, dac_sdi, dac_cs_n, busy, frame_abort;

  dac_write_ctrl dut (
    .clk12Mhz(clk), .RESET(RESET), .dac_ready(dac_ready),
    .cfg_req(cfg_req), .cfg_word(cfg_word), .cfg_ack(cfg_ack),
    .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(smp_ready),
    .dac_sclk(dac_sclk), .dac_sdi(dac_sdi), .dac_cs_n(dac_cs_n),
    .busy(busy), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] word;
    int          nbits;
    int          low;
    bit          abort;
  } exp_t;
  exp_t q[$];

  int nchk = 0;
  int nerr = 0;
  int viol = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [15:0] w, input int nb, input int low, input bit ab);
    exp_t e;
    e.word = w; e.nbits = nb; e.low = low; e.abort = ab;
    q.push_back(e);
  endtask

  // Returns at posedge+2 of the cycle in which the handshake is seen.
  task automatic wait_hs(input bit cfg, output int at);
    int n;
    n = 0;
    #1;
    while (!(cfg ? cfg_ack : (smp_ready && smp_valid)) && n < 200) begin
      @(posedge clk); #2; n++;
    end
    if (n >= 200) check("hs_timeout", 32'd0, 32'd1);
    at = cyc;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin tick(); n++; end
    if (n >= 200) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // Pin monitor: captures SDI on SCLK rise while CS_n low, scores on CS_n rise.
  logic [15:0] cap = '0;
  int nb = 0, low = 0;
  logic prev_sclk = 1'b0, prev_cs = 1'b1;
  always @(negedge clk) begin
    if (dac_cs_n === 1'b0) begin
      low++;
      if (dac_sclk === 1'b1 && prev_sclk === 1'b0) begin
        cap = {cap[14:0], dac_sdi};
        nb++;
      end
    end else if (prev_cs === 1'b0) begin
      if (q.size() == 0) begin
        check("unexpected_frame", {16'd0, cap}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("frame_bits", nb, e.nbits);
        check("frame_data", {16'd0, cap}, {16'd0, e.word >> (16 - e.nbits)});
        check("cs_low_cycles", low, e.low);
        check("frame_abort", {31'd0, frame_abort}, {31'd0, e.abort});
      end
      cap = '0; nb = 0; low = 0;
    end
    if (dac_sclk === 1'b1 && dac_cs_n !== 1'b0) viol++;
    prev_sclk = dac_sclk;
    prev_cs   = dac_cs_n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, prev;

    // Reset with requests pending: nothing may be acknowledged.
    dac_ready = 1'b1; smp_valid = 1'b1; cfg_req = 1'b1; cfg_word = 16'h5555;
    repeat (3) tick();
    check("rst_cfg_ack", {31'd0, cfg_ack}, 32'd0);
    check("rst_smp_ready", {31'd0, smp_ready}, 32'd0);
    check("rst_cs_n", {31'd0, dac_cs_n}, 32'd1);
    check("rst_sclk", {31'd0, dac_sclk}, 32'd0);
    check("rst_sdi", {31'd0, dac_sdi}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_abort", {31'd0, frame_abort}, 32'd0);

    // Sample frame and frame period.
    RESET = 1'b0; cfg_req = 1'b0; smp_data = 12'hABC;
    wait_hs(1'b0, a);
    push(16'h3ABC, 16, 32, 1'b0);
    tick();
    smp_data = 12'h123;
    check("shift_smp_ready", {31'd0, smp_ready}, 32'd0);
    check("shift_busy", {31'd0, busy}, 32'd1);
    check("shift_cs_n", {31'd0, dac_cs_n}, 32'd0);
    check("first_bit", {31'd0, dac_sdi}, 32'd0);
    wait_hs(1'b0, b);
    push(16'h3123, 16, 32, 1'b0);
    check("frame_period", b - a, 32'd35);
    tick(); smp_valid = 1'b0;
    wait_idle();

    // Config beats a simultaneous sample.
    cfg_req = 1'b1; cfg_word = 16'hF00F; smp_valid = 1'b1; smp_data = 12'h456;
    wait_hs(1'b1, a);
    check("prio_smp_ready", {31'd0, smp_ready}, 32'd0);
    push(16'hF00F, 16, 32, 1'b0);
    tick(); cfg_req = 1'b0;
    wait_hs(1'b0, b);
    push(16'h3456, 16, 32, 1'b0);
    check("sample_after_cfg", b - a, 32'd35);
    tick(); smp_valid = 1'b0;
    wait_idle();

    // dac_ready low blocks acceptance; rising edge accepts same cycle.
    dac_ready = 1'b0; cfg_req = 1'b1; cfg_word = 16'h1234;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("blocked_ack", {31'd0, cfg_ack}, 32'd0);
      check("blocked_cs_n", {31'd0, dac_cs_n}, 32'd1);
    end
    dac_ready = 1'b1;
    #1;
    check("ready_rise_ack", {31'd0, cfg_ack}, 32'd1);
    push(16'h1234, 16, 32, 1'b0);
    tick(); cfg_req = 1'b0;
    wait_idle();

    // Abort at the 6th SCLK high.
    smp_valid = 1'b1; smp_data = 12'h5A5;
    wait_hs(1'b0, a);
    push(16'h35A5, 6, 12, 1'b1);
    tick(); smp_valid = 1'b0;
    while (cyc != a + 12) tick();
    check("abort_sclk_high", {31'd0, dac_sclk}, 32'd1);
    dac_ready = 1'b0;
    tick();
    dac_ready = 1'b1; smp_valid = 1'b1; smp_data = 12'h0F0;
    check("abort_cs_n", {31'd0, dac_cs_n}, 32'd1);
    check("abort_pulse", {31'd0, frame_abort}, 32'd1);
    check("abort_sclk", {31'd0, dac_sclk}, 32'd0);
    wait_hs(1'b0, b);
    check("abort_gap", b - a, 32'd15);
    push(16'h30F0, 16, 32, 1'b0);
    tick(); smp_valid = 1'b0;
    check("abort_pulse_once", {31'd0, frame_abort}, 32'd0);
    wait_idle();

    // Reset mid-frame at cycle 10.
    smp_valid = 1'b1; smp_data = 12'h777;
    wait_hs(1'b0, a);
    push(16'h3777, 5, 10, 1'b0);
    tick(); smp_data = 12'h888;
    while (cyc != a + 10) tick();
    RESET = 1'b1;
    #1;
    check("rst_mid_smp_ready", {31'd0, smp_ready}, 32'd0);
    tick();
    RESET = 1'b0;
    check("rstmid_cs_n", {31'd0, dac_cs_n}, 32'd1);
    check("rstmid_sclk", {31'd0, dac_sclk}, 32'd0);
    check("rstmid_sdi", {31'd0, dac_sdi}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_abort", {31'd0, frame_abort}, 32'd0);
    wait_hs(1'b0, b);
    check("rst_release_accept", b - a, 32'd11);
    push(16'h3888, 16, 32, 1'b0);
    prev = b;
    tick();

    // Continuous samples: back-to-back frames at the fixed period.
    for (int i = 0; i < 4; i++) begin
      smp_data = 12'(12'h100 + 12'h101 * i);
      wait_hs(1'b0, b);
      push({4'h3, smp_data}, 16, 32, 1'b0);
      check("stream_spacing", b - prev, 32'd35);
      prev = b;
      tick();
    end
    smp_valid = 1'b0;

    for (int n = 0; n < 200 && q.size() != 0; n++) tick();
    check("queue_drained", q.size(), 32'd0);
    check("sclk_while_cs_high", viol, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
